// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects the two ALU operands from register, immediate,
// forwarded and constant sources, and buffers them in a two-entry skid buffer.

module alu_operand_sel #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ZERO_CONST = '0
) (
  input  logic                  src1_sel,
  input  logic [1:0]            src2_sel,
  input  logic [DATA_WIDTH-1:0] reg_op1,
  input  logic [DATA_WIDTH-1:0] reg_op2,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2
);

  always_comb begin
    op1 = src1_sel ? fwd_data : reg_op1;
    op2 = reg_op2;
    case (src2_sel)
      2'd0:    op2 = reg_op2;
      2'd1:    op2 = imm_op;
      2'd2:    op2 = fwd_data;
      default: op2 = ZERO_CONST;
    endcase
  end

endmodule

module alu_operand_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ZERO_CONST = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] reg_op1,
  input  logic [DATA_WIDTH-1:0] reg_op2,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  input  logic                  src1_sel,
  input  logic [1:0]            src2_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
  } pair_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_nxt;
  pair_t  main_q, skid_q, sel_pair;
  logic   accept, pop;
  logic   load_main_in, load_main_skid, load_skid;

  alu_operand_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ZERO_CONST (ZERO_CONST)
  ) u_sel (
    .src1_sel (src1_sel),
    .src2_sel (src2_sel),
    .reg_op1  (reg_op1),
    .reg_op2  (reg_op2),
    .imm_op   (imm_op),
    .fwd_data (fwd_data),
    .op1      (sel_pair.op1),
    .op2      (sel_pair.op2)
  );

  // Handshake flags come from registered state only, so in_ready never
  // depends on out_ready combinationally.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign alu_op1   = main_q.op1;
  assign alu_op2   = main_q.op2;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        main_q <= sel_pair;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= sel_pair;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a scoreboard of expected operand pairs.

module tb_alu_operand_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] reg_op1, reg_op2, imm_op, fwd_data;
  logic          src1_sel;
  logic [1:0]    src2_sel;
  logic          out_valid, out_ready;
  logic [DW-1:0] alu_op1, alu_op2;

  logic [2*DW-1:0] sbq[$];
  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int pops0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_WIDTH(DW), .ZERO_CONST('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reg_op1   (reg_op1),
    .reg_op2   (reg_op2),
    .imm_op    (imm_op),
    .fwd_data  (fwd_data),
    .src1_sel  (src1_sel),
    .src2_sel  (src2_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2)
  );

  // Output transfers happen at the next rising edge; inputs are stable from posedge+1.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [2*DW-1:0] exp;
      tests++;
      assert (sbq.size() != 0)
      else begin
        fails++;
        $error("FAIL unexpected_pop observed=%h expected=none", {alu_op1, alu_op2});
      end
      if (sbq.size() != 0) begin
        exp = sbq.pop_front();
        tests++;
        assert ({alu_op1, alu_op2} === exp)
        else begin
          fails++;
          $error("FAIL pop_data observed=%h expected=%h", {alu_op1, alu_op2}, exp);
        end
      end
      pops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] model(input logic s1, input logic [1:0] s2,
      input logic [DW-1:0] r1, input logic [DW-1:0] r2,
      input logic [DW-1:0] im, input logic [DW-1:0] fw);
    logic [DW-1:0] a, b;
    a = s1 ? fw : r1;
    case (s2)
      2'd0: b = r2;
      2'd1: b = im;
      2'd2: b = fw;
      default: b = '0;
    endcase
    return {a, b};
  endfunction

  // Set inputs for the coming edge; record the expected pair if it will be accepted.
  task automatic drive(input logic v, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
      input logic [DW-1:0] im, input logic [DW-1:0] fw, input logic s1, input logic [1:0] s2);
    in_valid = v; reg_op1 = r1; reg_op2 = r2; imm_op = im; fwd_data = fw;
    src1_sel = s1; src2_sel = s2;
    if (v && in_ready === 1'b1 && rst_n === 1'b1)
      sbq.push_back(model(s1, s2, r1, r2, im, fw));
  endtask

  task automatic idle();
    drive(1'b0, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004, 1'b1, 2'd2);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; reg_op1 = '0; reg_op2 = '0; imm_op = '0; fwd_data = '0;
    src1_sel = 1'b0; src2_sel = 2'd0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op1", alu_op1, '0);
    chk("rst_alu_op2", alu_op2, '0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // single pass
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 32'h99, 32'hFFFF_FFF0, 32'h77, 1'b0, 2'd1);
    step();
    idle();
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_op1", alu_op1, 32'h11);
    chk("single_op2", alu_op2, 32'hFFFF_FFF0);
    step();
    chk("single_drained", 32'(out_valid), 32'd0);

    // all selects, streamed back to back
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 32'h5, 32'hA, 32'hB, 32'hC, 1'b0, 2'(s));
      step();
    end
    drive(1'b1, 32'h5, 32'hA, 32'hB, 32'hC, 1'b1, 2'd0);
    step();
    idle();
    chk("sel1_fwd_op1", alu_op1, 32'hC);
    step();

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h101, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    drive(1'b1, 32'h200, 32'h201, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    drive(1'b1, 32'h300, 32'h301, 32'h0, 32'h0, 1'b0, 2'd0);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_hold_op1", alu_op1, 32'h100);
    step();
    idle();
    chk("bp_hold2_op1", alu_op1, 32'h100);
    chk("bp_hold2_op2", alu_op2, 32'h101);
    out_ready = 1'b1;
    step();
    chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_second_op1", alu_op1, 32'h200);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // throughput: one pair per cycle
    pops0 = pops;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'(i + 100), 32'h0, 32'h0, 1'b0, 2'd0);
      step();
      chk("tp_out_valid", 32'(out_valid), 32'd1);
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      chk("tp_op1", alu_op1, 32'(i));
    end
    idle();
    step();
    chk("tp_pop_count", 32'(pops - pops0), 32'd8);

    // reset while holding two pairs
    out_ready = 1'b0;
    drive(1'b1, 32'hAAA1, 32'hBBB1, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    drive(1'b1, 32'hAAA2, 32'hBBB2, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    rst_n = 1'b0;
    out_ready = 1'b1;
    sbq.delete();
    drive(1'b1, 32'hAAA3, 32'hBBB3, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    rst_n = 1'b1;
    idle();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_op1", alu_op1, '0);
    chk("mid_rst_op2", alu_op2, '0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    chk("mid_rst_no_ghost", 32'(out_valid), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
